// File: rtl/fsm_tb_pkg.sv
// Shared types and constants for the control-FSM stimulus sequencer.
// Widths here are the defaults; the sequencer re-derives widths from its parameters.
package fsm_tb_pkg;
   localparam int IN_W       = 7;
   localparam int HOLD_W_DEF = 6;
   localparam logic [IN_W-1:0] IDLE_VEC_DEF = '0;

   typedef enum logic [1:0] {IDLE, RST_DUT, PLAY, DONE} state_e;

   typedef struct packed {
      logic [IN_W-1:0]       data;
      logic [HOLD_W_DEF-1:0] hold;
   } entry_t;
endpackage

// File: rtl/stim_vec_ram.sv
// Vector buffer: synchronous write, asynchronous read.
// The sequencer registers the read data, so the async read does not reach a port.
module stim_vec_ram #(
   parameter int DEPTH = 64,
   parameter int W     = 13,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fsm_stim_sequencer.sv
// Stimulus sequencer: buffers {vector, hold} entries, pulses the FSM reset,
// then replays the entries cycle-accurately (once or looped) with a cycle counter.
module fsm_stim_sequencer
   import fsm_tb_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int HOLD_W     = 6,
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 16,
   parameter logic [IN_W-1:0] IDLE_VEC = IDLE_VEC_DEF,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [IN_W-1:0]   ld_data_i,
   input  logic [HOLD_W-1:0] ld_hold_i,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic              loop_en_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              empty_err_o,
   output logic [AW:0]       count_o,
   output logic              dut_rst_o,
   output logic [IN_W-1:0]   dut_in_o,
   output logic [AW-1:0]     vec_idx_o,
   output logic [CNT_W-1:0]  cyc_cnt_o
);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   state_e              state_q, state_d;
   logic [AW:0]         count_q, count_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [HOLD_W-1:0]   cur_hold_q, cur_hold_d;
   logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
   logic                loop_q, loop_d;
   logic [IN_W-1:0]     dut_in_q, dut_in_d;
   logic                dut_rst_q, dut_rst_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cyc_q, cyc_d;

   logic                wr_en, adv, last;
   logic [AW-1:0]       rd_addr;
   logic [IN_W+HOLD_W-1:0] rd_data;

   // Read port always points at the entry that would be loaded on an advance.
   assign last    = ({1'b0, rd_ptr_q} == count_q - 1'b1);
   assign rd_addr = (state_q == PLAY && !last) ? rd_ptr_q + 1'b1 : '0;

   stim_vec_ram #(.DEPTH(DEPTH), .W(IN_W+HOLD_W)) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i ({ld_data_i, ld_hold_i}),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign ld_ready_o = (state_q == IDLE) && (count_q < CNT_FULL);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      hold_cnt_d = hold_cnt_q;
      cur_hold_d = cur_hold_q;
      rst_cnt_d  = rst_cnt_q;
      loop_d     = loop_q;
      dut_in_d   = dut_in_q;
      dut_rst_d  = dut_rst_q;
      cyc_d      = cyc_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wr_en      = 1'b0;
      adv        = 1'b0;
      unique case (state_q)
         IDLE: begin
            // start outranks clear and load so a start never sees a shrinking buffer
            if (start_i) begin
               if (count_q == '0) err_d = 1'b1;
               else begin
                  state_d   = RST_DUT;
                  loop_d    = loop_en_i;
                  rst_cnt_d = '0;
                  dut_rst_d = 1'b1;
                  cyc_d     = '0;
               end
            end else if (clear_i) begin
               count_d  = '0;
               wr_ptr_d = '0;
            end else if (ld_valid_i && ld_ready_o) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end
         end
         RST_DUT: begin
            if (abort_i) begin
               state_d   = IDLE;
               dut_rst_d = 1'b0;
               dut_in_d  = IDLE_VEC;
            end else if (rst_cnt_q == RST_LAST) begin
               state_d   = PLAY;
               dut_rst_d = 1'b0;
               adv       = 1'b1;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         PLAY: begin
            if (abort_i) begin
               state_d  = IDLE;
               dut_in_d = IDLE_VEC;
            end else if (hold_cnt_q == cur_hold_q && last && !loop_q) begin
               state_d  = DONE;
               done_d   = 1'b1;
               dut_in_d = IDLE_VEC;
            end else begin
               cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
               if (hold_cnt_q == cur_hold_q) adv = 1'b1;
               else hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
      endcase
      if (adv) begin
         rd_ptr_d   = rd_addr;
         hold_cnt_d = '0;
         cur_hold_d = rd_data[HOLD_W-1:0];
         dut_in_d   = rd_data[HOLD_W +: IN_W];
      end
      busy_d = (state_d == RST_DUT) || (state_d == PLAY);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         hold_cnt_q <= '0;
         cur_hold_q <= '0;
         rst_cnt_q  <= '0;
         loop_q     <= 1'b0;
         dut_in_q   <= IDLE_VEC;
         dut_rst_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         cyc_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         cur_hold_q <= cur_hold_d;
         rst_cnt_q  <= rst_cnt_d;
         loop_q     <= loop_d;
         dut_in_q   <= dut_in_d;
         dut_rst_q  <= dut_rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         cyc_q      <= cyc_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign empty_err_o = err_q;
   assign count_o     = count_q;
   assign dut_rst_o   = dut_rst_q;
   assign dut_in_o    = dut_in_q;
   assign vec_idx_o   = rd_ptr_q;
   assign cyc_cnt_o   = cyc_q;
endmodule

// File: doc/fsm_stim_sequencer.md
Name: fsm_stim_sequencer

Overview:
Programmable stimulus sequencer that drives the 7-bit input bus of a control FSM under test and sequences its reset. Vectors, each with a hold count, are loaded into a local buffer. On start, the block pulses the FSM reset, then plays the vectors cycle-accurately, once or looped. It exports a playback cycle counter that the assertion-window checkers use as their time base.

Parameters:
DEPTH, 64, number of vector entries (power of 2)
HOLD_W, 6, width of the per-entry hold count; entry is applied hold+1 cycles
RST_CYCLES, 2, cycles dut_rst is held high before playback (>=1)
CNT_W, 16, width of playback cycle counter
IDLE_VEC, 7'b0000000, value driven on dut_in when not playing

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ld_valid  in  1  load request
ld_ready  out  1  buffer accepts an entry this cycle
ld_data  in  7  vector to store
ld_hold  in  HOLD_W  hold count for the entry
clear  in  1  empties the buffer (IDLE only)
start  in  1  begin playback
loop_en  in  1  sampled at start; 1 = repeat the buffer until abort
abort  in  1  stop playback
busy  out  1  high in RST_DUT and PLAY
done  out  1  one-cycle pulse at end of non-loop playback
empty_err  out  1  one-cycle pulse when start is seen with an empty buffer
count  out  $clog2(DEPTH)+1  entries stored
dut_rst  out  1  reset to FSM under test
dut_in  out  7  registered stimulus to FSM under test
vec_idx  out  $clog2(DEPTH)  index of the entry currently driven
cyc_cnt  out  CNT_W  cycles since the first vector was applied; saturates

Behaviour:
- Reset: state=IDLE; count=0; wr_ptr=0; dut_in=IDLE_VEC; dut_rst=0; busy=done=empty_err=0; vec_idx=0; cyc_cnt=0; loop flag=0. Buffer contents are don't-care.
- States: IDLE, RST_DUT, PLAY, DONE.
- Load:
  - ld_ready = (state==IDLE) && (count<DEPTH).
  - On ld_valid&&ld_ready: write {ld_data,ld_hold} at wr_ptr; wr_ptr++; count++.
  - When full, ld_valid is ignored and nothing is written.
  - clear in IDLE: count=0, wr_ptr=0. clear outside IDLE is ignored.
  - clear and ld_valid in the same cycle: clear wins and no write occurs.
- IDLE:
  - start with count==0: empty_err=1 for one cycle; remain in IDLE.
  - start with count>0: latch loop_en and go to RST_DUT.
  - start outranks ld_valid in the same cycle; the load is not accepted.
- RST_DUT:
  - dut_rst=1 and dut_in=IDLE_VEC for exactly RST_CYCLES cycles, then go to PLAY.
  - Start sampled at edge k: dut_rst is high for cycles k+1..k+RST_CYCLES; entry 0 appears on dut_in at cycle k+RST_CYCLES+1.
- PLAY:
  - dut_in = data[rd_ptr]; vec_idx = rd_ptr.
  - Hold counter starts at 0 for each entry and increments each cycle.
  - When hold counter == hold[rd_ptr], advance:
    - if rd_ptr == count-1 and the loop flag is set: rd_ptr=0 with no gap cycle;
    - if rd_ptr == count-1 and the loop flag is clear: go to DONE;
    - otherwise rd_ptr++.
  - cyc_cnt=0 on the first PLAY cycle, then increments each cycle and saturates at all-ones.
- DONE: lasts one cycle. done=1, dut_in=IDLE_VEC, then go to IDLE. cyc_cnt holds its value until the next start.
- abort in RST_DUT or PLAY:
  - next cycle: state=IDLE, dut_in=IDLE_VEC, dut_rst=0;
  - done is not pulsed; buffer and count are kept.
  - abort in IDLE or DONE has no effect.
- busy = (state==RST_DUT || state==PLAY), registered with the state.
- rst mid-playback returns all outputs to reset values on the next edge and empties the buffer.
- All outputs are registered; there are no combinational paths from inputs to outputs except ld_ready, which depends only on state and count.

Decomposition:
- Package fsm_tb_pkg holds: IN_W=7; state enum {IDLE,RST_DUT,PLAY,DONE}; the entry struct {data[IN_W], hold[HOLD_W]}; default IDLE_VEC.
- Sub-module stim_vec_ram: DEPTH x (7+HOLD_W), synchronous write, asynchronous read. The sequencer registers the read data into dut_in.

Test Plan:
- Load 3 entries {7'h40 hold 0, 7'h60 hold 2, 7'h41 hold 1}, start at cycle 10, RST_CYCLES=2 -> dut_rst high cycles 11-12; dut_in=40 at 13, 60 at 14-16, 41 at 17-18; done pulse at 19; busy high 11-18; cyc_cnt=5 at cycle 18.
- Same buffer with loop_en=1, abort at cycle 25 -> sequence repeats with no gap (40 at 19); IDLE at 26 with dut_in=00; done never pulses.
- start with an empty buffer -> empty_err=1 for one cycle; dut_rst, busy and dut_in stay unchanged.
- Load DEPTH entries -> ld_ready drops after the 64th write; a 65th ld_valid is not stored and count=64. clear then returns count=0 and ld_ready=1.
- Load an entry during PLAY -> ld_ready=0 and count is unchanged. Assert rst at PLAY entry 1 -> next cycle count=0, dut_in=00, busy=0.
- hold=63 (max) on a single entry -> vector driven 64 cycles; cyc_cnt reaches 63; CNT_W=4 variant saturates cyc_cnt at 15.
